// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM state encoding
//   NUM_REQ_DEF : default requester count, ID_W its grant index width
//   rr_next     : round-robin pick (first set bit after ptr, cyclic), -1 if none
`ifndef WIDTH
`define WIDTH 8
`endif

package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W        = $clog2(NUM_REQ_DEF);

    function automatic int rr_next(input int num_req, input int ptr, input logic [15:0] vec);
        int idx;
        rr_next = -1;
        // Walk from the farthest candidate to the nearest so the nearest set bit wins.
        for (int k = num_req; k >= 1; k--) begin
            idx = (ptr + k) % num_req;
            if (vec[idx[3:0]]) begin
                rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-write-side handshake bundle for fifo_wr_arbiter.
//   master : producers + FIFO (drive valid/data/last, full/overflow)
//   slave  : arbiter (drives req_ready, fifo_wr_en, fifo_wdata)
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = `WIDTH
);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_full;
    logic                     fifo_overflow;
    logic                     fifo_wr_en;
    logic [WIDTH-1:0]         fifo_wdata;

    modport master (
        output req_valid, req_data, req_last, fifo_full, fifo_overflow,
        input  req_ready, fifo_wr_en, fifo_wdata
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full, fifo_overflow,
        output req_ready, fifo_wr_en, fifo_wdata
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority pick.
//   req       : request vector
//   rr_ptr    : index of the last owner (lowest priority)
//   winner    : first set index scanning rr_ptr+1, rr_ptr+2, ... cyclically
//   any_valid : at least one request bit set
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
)(
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_valid
);

    localparam int IW = $clog2(NUM_REQ);

    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        // Farthest candidate first, so the closest one after rr_ptr overrides.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[idx[IW-1:0]]) begin
                winner    = idx[IW-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port between NUM_REQ
// producers in the write clock domain. Each grant is a burst lease of up to
// MAX_BURST beats, ended by last, beat limit or the owner dropping valid.
//   w_clk        : write-domain clock
//   rst          : synchronous active-low reset
//   bus          : requester handshake + FIFO write side (slave modport)
//   grant_id     : current owner, meaningful while busy
//   busy         : burst lease active
//   err_clr      : clears err_overflow (overflow on the same cycle wins)
//   err_overflow : sticky FIFO overflow seen
//
// state | meaning
// IDLE  | no lease; pick next requester after rr_ptr, grant on next edge
// BURST | grant_id owns the FIFO write port, beats pass through combinationally
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = `WIDTH,
    parameter int MAX_BURST = 4
)(
    input  logic                       w_clk,
    input  logic                       rst,
    fifo_wr_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    input  logic                       err_clr,
    output logic                       err_overflow
);

    localparam int IW     = $clog2(NUM_REQ);
    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_BURST = BURST;

    logic [0:0]        state;
    logic [IW-1:0]     rr_ptr;
    logic [BCNT_W-1:0] beat_cnt;
    logic [IW-1:0]     winner;
    logic              any_valid;
    logic              in_burst;
    logic              cur_valid;
    logic              cur_last;
    logic              accept;
    logic              lease_done;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Outputs are gated with rst so nothing is written on a reset cycle.
    assign in_burst  = rst && (state == S_BURST);
    assign cur_valid = bus.req_valid[grant_id];
    assign cur_last  = bus.req_last[grant_id];
    assign accept    = in_burst && cur_valid && !bus.fifo_full;
    assign busy      = in_burst;

    assign lease_done = cur_last || (beat_cnt == BCNT_W'(MAX_BURST - 1));

    always_comb begin
        bus.req_ready = '0;
        if (in_burst && !bus.fifo_full) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    assign bus.fifo_wr_en = accept;
    assign bus.fifo_wdata = accept ? bus.req_data[int'(grant_id)*WIDTH +: WIDTH] : '0;

    always_ff @(posedge w_clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            rr_ptr   <= IW'(NUM_REQ - 1);
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        grant_id <= winner;
                        beat_cnt <= '0;
                        state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    // A stall under fifo_full holds everything; only a dropped
                    // valid or an accepted final beat releases the lease.
                    if (!cur_valid) begin
                        state  <= S_IDLE;
                        rr_ptr <= grant_id;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + BCNT_W'(1);
                        if (lease_done) begin
                            state  <= S_IDLE;
                            rr_ptr <= grant_id;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge w_clk) begin
        if (!rst) begin
            err_overflow <= 1'b0;
        end else if (bus.fifo_overflow) begin
            err_overflow <= 1'b1;
        end else if (err_clr) begin
            err_overflow <= 1'b0;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the async FIFO between NUM_REQ requesters, all in the write clock domain.
- Each requester gets a burst lease of up to MAX_BURST beats. The lease ends on last, timeout or dropped valid, and the grant then rotates to the next requester.
- Never pushes while the FIFO reports full. Traps any overflow pulse into a sticky error flag.
- Sits between the producer blocks and the FIFO write side (wr_en, wdata, full, overflow).

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, `WIDTH, data width per beat
- MAX_BURST, 4, maximum beats per grant (1..255)

Ports:
- w_clk  input  1  write-domain clock
- rst  input  1  synchronous active-low reset, sampled on posedge w_clk
- req_valid  input  NUM_REQ  per-requester beat valid
- req_data  input  NUM_REQ*WIDTH  packed beat data; requester i occupies bits [i*WIDTH +: WIDTH]
- req_last  input  NUM_REQ  marks final beat of requester's burst
- req_ready  output  NUM_REQ  beat accepted this cycle when valid&ready
- fifo_full  input  1  FIFO full flag
- fifo_overflow  input  1  FIFO overflow flag
- fifo_wr_en  output  1  FIFO write enable
- fifo_wdata  output  WIDTH  FIFO write data
- grant_id  output  $clog2(NUM_REQ)  current owner; meaningful only while busy=1
- busy  output  1  high in BURST state
- err_clr  input  1  clears err_overflow
- err_overflow  output  1  sticky overflow-seen flag

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first), grant_id=0, beat_cnt=0, err_overflow=0. Outputs while rst=0: busy=0, req_ready=0, fifo_wr_en=0, fifo_wdata=0.
- Reset mid-burst aborts the burst immediately. No beat is written on the reset cycle.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid, winner = first set index scanning rr_ptr+1, rr_ptr+2, ... cyclically.
  - On the next edge: grant_id<=winner, beat_cnt<=0, state<=BURST.
  - req_ready is all-zero in IDLE, so arbitration latency is 1 cycle.
- BURST, for g=grant_id:
  - req_ready[g] = !fifo_full. All other req_ready bits are 0.
  - Accept = req_valid[g] & req_ready[g].
  - fifo_wr_en = accept, fifo_wdata = req_data[g]. Both are combinational, so 0-cycle latency from handshake to write.
  - fifo_wdata = 0 when fifo_wr_en=0.
  - beat_cnt increments on each accept.
- BURST exit to IDLE at the next edge, with rr_ptr<=g, on any of:
  - (a) accept with req_last[g]=1;
  - (b) accept with beat_cnt==MAX_BURST-1;
  - (c) req_valid[g]=0 (requester dropped, releases lease, no write).
- fifo_full=1 with req_valid[g]=1: stall. Grant held, beat_cnt frozen, no write, no timeout.
- fifo_full and req_last asserted together: no accept, burst continues until the beat is taken.
- IDLE with no valid: stay in IDLE; rr_ptr unchanged.
- Fairness: after g's burst, g has lowest priority. Any continuously-valid requester is granted within NUM_REQ-1 bursts.
- err_overflow:
  - Set on any cycle with fifo_overflow=1.
  - Cleared on err_clr=1 only when fifo_overflow=0 that cycle; set wins over clear.
  - Correct operation never sets it.
- beat_cnt width is $clog2(MAX_BURST+1). It never wraps because exit (b) fires first.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum arb_state_e {IDLE, BURST};
  - localparam ID_W = $clog2(NUM_REQ) default helper;
  - function rr_next(ptr, vec) for reference-model reuse in the bench.
- One sub-module, fifo_rr_pick: combinational round-robin priority pick. Inputs req vector and rr_ptr; outputs winner index and any_valid.

Test Plan:
- Reset then req_valid=4'b0001, 3 beats (0xA1,0xA2,0xA3, last on 3rd) -> busy rises 1 cycle later. fifo_wr_en pulses 3 times with 0xA1..0xA3. IDLE afterwards, rr_ptr=0.
- All four valid continuously, never last, MAX_BURST=4 -> grant order 0,1,2,3,0. Exactly 4 writes per grant. One idle cycle between grants.
- Requester 2 in BURST, fifo_full=1 for 5 cycles mid-burst -> req_ready[2]=0 and fifo_wr_en=0 for those 5 cycles, grant held. Remaining beats written after full drops. No beat is lost or duplicated.
- Requester 1 drops req_valid after 2 of 4 beats -> returns to IDLE. Next valid requester (3) is granted and requester 1 gets lowest priority.
- Force fifo_overflow=1 one cycle -> err_overflow=1 and stays. err_clr with overflow=0 -> 0. err_clr and overflow in the same cycle -> stays 1.
- rst=0 asserted mid-burst at beat 2 -> next cycle busy=0, fifo_wr_en=0. After release, requester 0 wins first even if requester 3 is also valid.
